// File: rtl/wb_mem_arbiter_if.sv
// Single-beat Wishbone bus bundle shared by the fetch port, the load/store port and the memory slave.
// "master" drives the request side; "slave" drives the ack/err/stall/read-data side.
interface wb_mem_arbiter_if #(
    parameter int ADDR_W = 10
);
    logic              cyc;
    logic              stb;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        sel;
    logic              ack;
    logic              err;
    logic              stall;
    logic [31:0]       rdata;

    modport master (
        output cyc, stb, we, addr, wdata, sel,
        input  ack, err, stall, rdata
    );

    modport slave (
        input  cyc, stb, we, addr, wdata, sel,
        output ack, err, stall, rdata
    );
endinterface

// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone arbiter (m0 = instruction fetch, m1 = load/store) in front of one memory slave.
// Define WB_ARB_RR_EN for round-robin tie-break; otherwise fixed priority m1 over m0.
//
//  state | meaning
//  IDLE  | no owner, arbitrate and latch the winner's request
//  ISSUE | strobe latched request to slave until it is not stalled
//  WAIT  | cycle held, waiting for slave ack or timeout
module wb_mem_arbiter #(
    parameter int ADDR_W         = 10,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    wb_mem_arbiter_if.slave  m0,
    wb_mem_arbiter_if.slave  m1,
    wb_mem_arbiter_if.master s,
    output logic [1:0]       o_grant
);
    localparam int               CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam bit               TO_EN  = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state_q, state_d;
    logic              owner_q;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_data;
    logic [3:0]        lat_sel;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       rd0_q, rd1_q;
    logic              req0, req1, win, owner_cyc, ack_ev, err_ev, busy;
`ifdef WB_ARB_RR_EN
    logic              last_q;
`endif

    always_comb begin
        req0      = m0.cyc & m0.stb;
        req1      = m1.cyc & m1.stb;
`ifdef WB_ARB_RR_EN
        win       = (req0 & req1) ? ~last_q : req1;
`else
        win       = req1;
`endif
        owner_cyc = owner_q ? m1.cyc : m0.cyc;
        state_d   = state_q;
        ack_ev    = 1'b0;
        err_ev    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 | req1) state_d = ISSUE;
            end
            ISSUE: begin
                if (!owner_cyc)    state_d = IDLE;
                else if (!s.stall) state_d = WAIT;
            end
            WAIT: begin
                // an owner abort wins over a coincident ack or timeout
                if (!owner_cyc) begin
                    state_d = IDLE;
                end else if (s.ack) begin
                    ack_ev  = 1'b1;
                    state_d = IDLE;
                end else if (TO_EN && cnt_q == TO_VAL) begin
                    err_ev  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign o_grant  = busy ? {owner_q, ~owner_q} : 2'b00;

    assign s.cyc    = busy & owner_cyc;
    assign s.stb    = (state_q == ISSUE) & owner_cyc;
    assign s.we     = busy & lat_we;
    assign s.addr   = busy ? lat_addr : '0;
    assign s.wdata  = busy ? lat_data : '0;
    assign s.sel    = busy ? lat_sel  : '0;

    assign m0.ack   = ack_ev & ~owner_q;
    assign m1.ack   = ack_ev &  owner_q;
    assign m0.err   = err_ev & ~owner_q;
    assign m1.err   = err_ev &  owner_q;
    assign m0.stall = ~((state_q == ISSUE) & ~owner_q);
    assign m1.stall = ~((state_q == ISSUE) &  owner_q);
    assign m0.rdata = (ack_ev & ~owner_q) ? s.rdata : rd0_q;
    assign m1.rdata = (ack_ev &  owner_q) ? s.rdata : rd1_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            lat_we   <= 1'b0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_sel  <= '0;
            cnt_q    <= '0;
            rd0_q    <= '0;
            rd1_q    <= '0;
`ifdef WB_ARB_RR_EN
            last_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && (req0 | req1)) begin
                owner_q  <= win;
                lat_we   <= win ? m1.we    : m0.we;
                lat_addr <= win ? m1.addr  : m0.addr;
                lat_data <= win ? m1.wdata : m0.wdata;
                lat_sel  <= win ? m1.sel   : m0.sel;
            end
            if (state_q != WAIT)     cnt_q <= '0;
            else if (cnt_q != TO_VAL) cnt_q <= cnt_q + 1'b1;
            if (ack_ev & ~owner_q) rd0_q <= s.rdata;
            if (ack_ev &  owner_q) rd1_q <= s.rdata;
`ifdef WB_ARB_RR_EN
            if (ack_ev | err_ev) last_q <= owner_q;
`endif
        end
    end
endmodule
